// File: rtl/exp_test_pkg.sv
// Shared types and float32 helpers for the e^x core self-test driver.
package exp_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    WAIT_RDY,
    LOAD,
    WAIT_RES,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MANT_MSB = 22;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[EXP_MSB:EXP_LSB] == EXP_MAX) && (f[MANT_MSB:0] != '0);
  endfunction

endpackage

// File: rtl/f32_ulp_compare.sv
// Combinational float32 result check: NaN/zero/sign rules, then magnitude
// distance in ULPs against a fixed tolerance.
module f32_ulp_compare
  import exp_test_pkg::*;
#(
  parameter int unsigned ULP_TOL = 2
) (
  input  logic [31:0] ref_f,
  input  logic [31:0] out_f,
  output logic        pass
);

  logic [30:0] ref_mag;
  logic [30:0] out_mag;
  logic [30:0] diff;

  always_comb begin
    ref_mag = ref_f[EXP_MSB:0];
    out_mag = out_f[EXP_MSB:0];
    diff    = (out_mag >= ref_mag) ? (out_mag - ref_mag) : (ref_mag - out_mag);
    if (is_nan(ref_f))
      pass = is_nan(out_f);
    else if ((ref_mag == '0) && (out_mag == '0))
      pass = 1'b1;
    else if (ref_f[SIGN_BIT] != out_f[SIGN_BIT])
      pass = 1'b0;
    else
      pass = (diff <= 31'(ULP_TOL));
  end

endmodule

// File: rtl/exp_selftest_driver.sv
// Self-test initiator: streams ROM vectors into the e^x core, checks each
// result within ULP_TOL and accumulates pass/fail statistics.
module exp_selftest_driver
  import exp_test_pkg::*;
#(
  parameter int unsigned NUM_VEC = 100,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned ULP_TOL = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [63:0]       vec_data,
  output logic              load,
  output logic [31:0]       FLOAT32_IN,
  input  logic              input_ready,
  input  logic              output_ready,
  input  logic [31:0]       FLOAT32_OUT,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ADDR_W:0]   pass_count,
  output logic [ADDR_W:0]   fail_count,
  output logic [ADDR_W-1:0] first_fail
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]     TLIM     = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       ref_r;
  logic [31:0]       res_r;
  logic [TW-1:0]     tcnt;
  logic              waiting;
  logic              advance;
  logic              vec_pass;

  f32_ulp_compare #(.ULP_TOL(ULP_TOL)) u_cmp (
    .ref_f (ref_r),
    .out_f (res_r),
    .pass  (vec_pass)
  );

  always_comb begin
    waiting = (state == WAIT_RDY) || (state == LOAD) || (state == WAIT_RES);
    advance = ((state == WAIT_RDY) &&  input_ready) ||
              ((state == LOAD)     && !input_ready) ||
              ((state == WAIT_RES) &&  output_ready);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      ref_r       <= '0;
      res_r       <= '0;
      tcnt        <= '0;
      vec_addr    <= '0;
      load        <= 1'b0;
      FLOAT32_IN  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      pass_count  <= '0;
      fail_count  <= '0;
      first_fail  <= '0;
    end else if (waiting && !advance && (tcnt == TLIM)) begin
      // Abort keeps the counters as they stand.
      state       <= DONE;
      tcnt        <= '0;
      load        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b1;
      timeout_err <= 1'b1;
    end else begin
      tcnt <= (waiting && !advance) ? tcnt + 1'b1 : '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= FETCH;
            idx         <= '0;
            vec_addr    <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
            first_fail  <= '0;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          FLOAT32_IN <= vec_data[63:32];
          ref_r      <= vec_data[31:0];
          state      <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (input_ready) begin
            load  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!input_ready) begin
            load  <= 1'b0;
            state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (output_ready) begin
            res_r <= FLOAT32_OUT;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (vec_pass) begin
            pass_count <= pass_count + 1'b1;
          end else begin
            fail_count <= fail_count + 1'b1;
            if (fail_count == '0)
              first_fail <= idx;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx      <= idx + 1'b1;
            vec_addr <= idx + 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_selftest_driver.sv
// Directed bench for exp_selftest_driver: ROM + handshake core stand-in driven
// from one initial block, expected verdicts queued and retired per vector.
module tb_exp_selftest_driver;

  localparam int unsigned NV = 100;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  vec_addr;
  logic [63:0] vec_data = '0;
  logic        load;
  logic [31:0] FLOAT32_IN;
  logic        input_ready = 1'b1;
  logic        output_ready = 1'b0;
  logic [31:0] FLOAT32_OUT = '0;
  logic        busy, done, timeout_err;
  logic [7:0]  pass_count, fail_count;
  logic [6:0]  first_fail;

  logic [31:0] stim_t [NV];
  logic [31:0] ref_t  [NV];
  logic [31:0] out_t  [NV];
  logic        exp_pass [NV];
  logic [63:0] rom [128];
  bit          exp_q [$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          exp_pc, exp_fc, exp_ff;

  exp_selftest_driver #(
    .NUM_VEC (100),
    .ADDR_W  (7),
    .ULP_TOL (2),
    .TIMEOUT (1024)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .start        (start),
    .vec_addr     (vec_addr),
    .vec_data     (vec_data),
    .load         (load),
    .FLOAT32_IN   (FLOAT32_IN),
    .input_ready  (input_ready),
    .output_ready (output_ready),
    .FLOAT32_OUT  (FLOAT32_OUT),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .first_fail   (first_fail)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) vec_data <= rom[vec_addr];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_load"}, load, 1'b0);
    check({tag, "_fin"}, FLOAT32_IN, 32'h0);
    check({tag, "_addr"}, vec_addr, 7'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_tmo"}, timeout_err, 1'b0);
    check({tag, "_pc"}, pass_count, 8'h0);
    check({tag, "_fc"}, fail_count, 8'h0);
    check({tag, "_ff"}, first_fail, 7'h0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One full handshake for vector i: hold = cycles load is seen high before
  // input_ready drops, lat = idle cycles before output_ready, early = drive a
  // bogus result while still in LOAD.
  task automatic serve_vector(input int i, input int hold, input int lat, input bit early);
    int k = 0;
    while (load !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("load_rise", load, 1'b1);
    check("stim", FLOAT32_IN, stim_t[i]);
    if (early) begin
      output_ready = 1'b1;
      FLOAT32_OUT  = 32'hDEADBEEF;
    end
    for (int c = 1; c < hold; c++) begin
      tick();
      check("load_hold", load, 1'b1);
      check("stim_hold", FLOAT32_IN, stim_t[i]);
    end
    input_ready  = 1'b0;
    output_ready = 1'b0;
    tick();
    check("load_fall", load, 1'b0);
    for (int c = 0; c < lat; c++) tick();
    output_ready = 1'b1;
    FLOAT32_OUT  = out_t[i];
    input_ready  = 1'b1;
    exp_q.push_back(exp_pass[i]);
    tick();
    output_ready = 1'b0;
    FLOAT32_OUT  = '0;
    tick();
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1'b1, 1'b0);
    end else if (exp_q.pop_front()) begin
      exp_pc++;
    end else begin
      if (exp_fc == 0) exp_ff = i;
      exp_fc++;
    end
    check("pass_count", pass_count, 8'(exp_pc));
    check("fail_count", fail_count, 8'(exp_fc));
    if (exp_fc != 0) check("first_fail", first_fail, 7'(exp_ff));
  endtask

  task automatic clear_model();
    exp_pc = 0;
    exp_fc = 0;
    exp_ff = 0;
    exp_q.delete();
  endtask

  initial begin
    int unsigned e, mt, d;
    logic [30:0] m, om;
    int cyc;

    for (int i = 0; i < int'(NV); i++) begin
      e  = $urandom_range(1, 253);
      mt = $urandom_range(16, 8388591);
      d  = $urandom_range(0, 4);
      m  = {8'(e), 23'(mt)};
      om = (d >= 2) ? m + 31'(d - 2) : m - 31'(2 - d);
      stim_t[i]   = $urandom;
      ref_t[i]    = {1'($urandom_range(0, 1)), m};
      out_t[i]    = {ref_t[i][31], om};
      exp_pass[i] = 1'b1;
    end
    stim_t[0] = 32'h00000000; ref_t[0] = 32'h3F800000; out_t[0] = 32'h3F800000;
    ref_t[1]  = 32'h402DF854; out_t[1]  = 32'h402DF852;
    ref_t[2]  = 32'h402DF854; out_t[2]  = 32'h402DF856;
    ref_t[3]  = 32'h7FC00000; out_t[3]  = 32'h7F800001;
    ref_t[4]  = 32'h80000000; out_t[4]  = 32'h00000000;
    ref_t[5]  = 32'hFF800000; out_t[5]  = 32'hFF800000;
    ref_t[6]  = 32'h00000000; out_t[6]  = 32'h80000000;
    ref_t[7]  = 32'h402DF854; out_t[7]  = 32'h402DF857; exp_pass[7]  = 1'b0;
    ref_t[40] = 32'h3F800000; out_t[40] = 32'hBF800000; exp_pass[40] = 1'b0;
    ref_t[99] = 32'h7FC00000; out_t[99] = 32'h7F800000; exp_pass[99] = 1'b0;
    for (int i = 0; i < 128; i++)
      rom[i] = (i < int'(NV)) ? {stim_t[i], ref_t[i]} : 64'h0;

    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // Run A: partial run, ignored start, then mid-run reset.
    clear_model();
    pulse_start();
    check("startA_busy", busy, 1'b1);
    check("startA_done", done, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i == 10) pulse_start();
      serve_vector(i, (i == 2) ? 5 : 1, i % 3, (i == 1));
    end
    check("runA_busy", busy, 1'b1);
    cyc = 0;
    while (load !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("runA_load12", load, 1'b1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_busy", busy, 1'b0);

    // Run B: full 100-vector run from IDLE.
    clear_model();
    pulse_start();
    check("startB_busy", busy, 1'b1);
    for (int i = 0; i < int'(NV); i++)
      serve_vector(i, (i % 3) + 1, i % 4, (i == 1));
    check("runB_done", done, 1'b1);
    check("runB_busy", busy, 1'b0);
    check("runB_tmo", timeout_err, 1'b0);
    check("runB_pc", pass_count, 8'd97);
    check("runB_fc", fail_count, 8'd3);
    check("runB_ff", first_fail, 7'd7);
    tick();
    tick();
    check("runB_done_held", done, 1'b1);

    // Run C: restart from DONE, then core never accepts vector 1.
    clear_model();
    pulse_start();
    check("startC_done", done, 1'b0);
    check("startC_pc", pass_count, 8'd0);
    check("startC_fc", fail_count, 8'd0);
    check("startC_busy", busy, 1'b1);
    serve_vector(0, 1, 0, 1'b0);
    cyc = 0;
    while (load !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("tmo_load_rise", load, 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("tmo_cycles", cyc, 1024);
    check("tmo_err", timeout_err, 1'b1);
    check("tmo_done", done, 1'b1);
    check("tmo_load", load, 1'b0);
    check("tmo_busy", busy, 1'b0);
    check("tmo_pc", pass_count, 8'd1);
    check("tmo_fc", fail_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
